sad_accum: RTL and testbench

SAD_ACCUM -- requirements
Module: sad_accum

---
 rtl/sad_pkg.sv | 21 ++
 rtl/abs_diff_stage.sv | 62 ++++++
 rtl/sad_accum.sv | 123 ++++++++++++
 tb/tb_sad_accum.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// -----------------------------------------------------------------------------
// sad_pkg -- shared types and helpers for the sum-of-absolute-differences
// accumulator.
//   sad_state_t : frame FSM states (IDLE, ACCUM, DRAIN, HOLD)
//   sum_width() : accumulator width needed to hold FRAME * (2^WIDTH - 1)
// -----------------------------------------------------------------------------
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE,   // no samples in the current frame yet
    ACCUM,  // at least one sample accepted, frame still open
    DRAIN,  // frame closed, last sample still travelling through stage 1
    HOLD    // result presented on out_sum / out_count
  } sad_state_t;

  // Each sample adds at most 2^width-1, so log2(frame+1) extra bits suffice.
  function automatic int sum_width(input int width, input int frame);
    return width + $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/abs_diff_stage.sv
// -----------------------------------------------------------------------------
// abs_diff_stage -- pipeline stage 1: registers d = |a - b| for every loaded
// sample, together with a valid flag.
//
// Optional feature: define SAD_APPROX_EN to drop TRUNC LSBs from each operand
// before subtracting (result is shifted back up). Without the macro the stage
// is exact and TRUNC has no effect.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         a new sample is accepted this cycle
//   a, b         unsigned operands (WIDTH bits)
//   d            registered absolute difference (WIDTH bits)
//   d_valid      d holds a sample that stage 2 has not yet absorbed
// -----------------------------------------------------------------------------
module abs_diff_stage
  import sad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TRUNC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             d_valid
);

`ifdef SAD_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  // A zero shift turns the approximate datapath into the exact one.
  localparam int SHIFT = APPROX ? TRUNC : 0;

  logic [WIDTH-1:0] a_s, b_s, mag, d_next;

  always_comb begin
    a_s    = a >> SHIFT;
    b_s    = b >> SHIFT;
    // Subtract the smaller from the larger so the unsigned result never wraps.
    mag    = (a_s >= b_s) ? (a_s - b_s) : (b_s - a_s);
    d_next = mag << SHIFT;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d       <= '0;
      d_valid <= 1'b0;
    end else begin
      d_valid <= load;
      if (load) d <= d_next;
    end
  end

endmodule

// File: rtl/sad_accum.sv
// -----------------------------------------------------------------------------
// sad_accum -- accumulates |a - b| over a frame of up to FRAME samples and
// presents the sum and sample count with a valid/ready handshake.
//
// A frame closes when FRAME samples have been accepted or when an accepted
// sample carries in_last. The result appears two cycles after the closing
// sample is accepted and is held until out_ready.
//
// Optional feature: SAD_APPROX_EN selects the truncated-operand datapath in
// stage 1 (see abs_diff_stage).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   sample handshake
//   in_a, in_b          unsigned operands
//   in_last             sample closes the frame early
//   out_valid/out_ready result handshake
//   out_sum             sum of |a-b| over the frame (SW bits)
//   out_count           number of samples in the frame
// -----------------------------------------------------------------------------
module sad_accum
  import sad_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int FRAME = 8,
  parameter  int TRUNC = 1,
  localparam int SW    = sum_width(WIDTH, FRAME),
  localparam int CW    = $clog2(FRAME + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    out_sum,
  output logic [CW-1:0]    out_count
);

  sad_state_t       state;
  logic [CW-1:0]    in_cnt;   // samples accepted into the open frame
  logic [CW-1:0]    acc_cnt;  // samples absorbed by stage 2
  logic [SW-1:0]    acc;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             accept;
  logic             closing;

  assign accept  = in_valid && in_ready;
  // in_last on the FRAME-th sample still closes only this one frame.
  assign closing = in_last || (in_cnt == CW'(FRAME - 1));

  abs_diff_stage #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC)
  ) u_stage1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .a       (in_a),
    .b       (in_b),
    .d       (d),
    .d_valid (d_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      in_cnt    <= '0;
      acc_cnt   <= '0;
      acc       <= '0;
    end else begin
      // Stage 2: absorb whatever stage 1 registered on the previous edge.
      if (d_valid) begin
        acc     <= acc + SW'(d);
        acc_cnt <= acc_cnt + CW'(1);
      end

      case (state)
        IDLE, ACCUM: begin
          // Also raises in_ready on the first edge after reset.
          in_ready <= 1'b1;
          if (accept) begin
            in_cnt <= in_cnt + CW'(1);
            if (closing) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state    <= ACCUM;
            end
          end
        end
        DRAIN: begin
          // Stage 1 empty means stage 2 has taken the closing sample.
          if (!d_valid) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            in_cnt    <= '0;
            acc_cnt   <= '0;
            acc       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_count = acc_cnt;

endmodule

// File: tb/tb_sad_accum.sv
// -----------------------------------------------------------------------------
// tb_sad_accum -- self-checking bench for sad_accum (WIDTH=4, FRAME=8,
// TRUNC=1). Directed frames plus randomized frames with input gaps, random
// early closes and output back-pressure; expected sums come from plain
// arithmetic over the offered samples.
// -----------------------------------------------------------------------------
module tb_sad_accum;

  localparam int WIDTH = 4;
  localparam int FRAME = 8;
  localparam int TRUNC = 1;
  localparam int SW    = WIDTH + $clog2(FRAME + 1);
  localparam int CW    = $clog2(FRAME + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_sum;
  logic [CW-1:0]    out_count;

  int n_checks = 0;
  int n_errors = 0;
  int sa [FRAME];
  int sb [FRAME];

  sad_accum #(
    .WIDTH (WIDTH),
    .FRAME (FRAME),
    .TRUNC (TRUNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference |a-b| per sample, straight from the arithmetic definition.
  function automatic int ref_diff(input int a, input int b);
`ifdef SAD_APPROX_EN
    int q = 1 << TRUNC;
    int x = a / q;
    int y = b / q;
    return ((x > y) ? (x - y) : (y - x)) * q;
`else
    return (a > b) ? (a - b) : (b - a);
`endif
  endfunction

  task automatic fill_const(input int a, input int b);
    for (int i = 0; i < FRAME; i++) begin
      sa[i] = a;
      sb[i] = b;
    end
  endtask

  // Offer samples sa/sb[0..n-1]; called and returns on a negedge.
  task automatic offer(input string name, input int n, input bit last_flag,
                       input bit gaps);
    int w;
    int a, b;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      a        = sa[i];
      b        = sb[i];
      in_valid = 1'b1;
      in_a     = a[WIDTH-1:0];
      in_b     = b[WIDTH-1:0];
      in_last  = last_flag && (i == n - 1);
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) check({name, "_ready_timeout"}, 0, 1);
      @(negedge clk);  // accepted on the edge just passed
    end
  endtask

  // Run one frame end to end: latency, result, hold stability, release.
  task automatic run_frame(input string name, input int n, input bit last_flag,
                           input int hold, input bit gaps);
    int exp_sum;
    int cyc;
    int junk;
    exp_sum = 0;
    for (int i = 0; i < n; i++) exp_sum += ref_diff(sa[i], sb[i]);
    out_ready = (hold == 0);
    offer(name, n, last_flag, gaps);

    // Keep offering junk: it must be ignored while in_ready is low.
    junk     = $urandom;
    in_valid = 1'b1;
    in_a     = junk[WIDTH-1:0];
    in_b     = junk[2*WIDTH-1:WIDTH];
    in_last  = junk[8];
    check({name, "_drain_ready"}, int'(in_ready), 0);

    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, 2);
    check({name, "_sum"}, int'(out_sum), exp_sum);
    check({name, "_count"}, int'(out_count), n);
    check({name, "_hold_ready"}, int'(in_ready), 0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_held_valid"}, int'(out_valid), 1);
      check({name, "_held_sum"}, int'(out_sum), exp_sum);
      check({name, "_held_ready"}, int'(in_ready), 0);
    end

    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_released_valid"}, int'(out_valid), 0);
    check({name, "_released_ready"}, int'(in_ready), 1);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen_valid;
    int n;
    bit last_flag;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    #2;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_count", int'(out_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", int'(in_ready), 1);

    // Full frame of maximum differences, consumer always ready.
    fill_const(15, 0);
    run_frame("full15", FRAME, 1'b0, 0, 1'b0);

    // Early close on the third sample.
    sa[0] = 3; sb[0] = 7;
    sa[1] = 9; sb[1] = 2;
    sa[2] = 5; sb[2] = 5;
    run_frame("early3", 3, 1'b1, 0, 1'b0);

    // Back-pressure for five cycles.
    for (int i = 0; i < FRAME; i++) begin
      sa[i] = $urandom_range(0, 15);
      sb[i] = $urandom_range(0, 15);
    end
    run_frame("hold5", FRAME, 1'b0, 5, 1'b0);

    // Single-sample frame.
    sa[0] = 0; sb[0] = 15;
    run_frame("single", 1, 1'b1, 0, 1'b0);

    // Operands that differ between exact and approximate builds.
    fill_const(7, 4);
    run_frame("approx74", FRAME, 1'b0, 0, 1'b0);

    // in_last on the FRAME-th sample closes a single frame.
    fill_const(2, 9);
    run_frame("last_at_frame", FRAME, 1'b1, 1, 1'b0);

    // Reset in the middle of a frame discards it.
    fill_const(6, 1);
    offer("partial", 4, 1'b0, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_sum", int'(out_sum), 0);
    check("midrst_count", int'(out_count), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", int'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_result", int'(seen_valid), 0);
    check("midrst_sum_idle", int'(out_sum), 0);
    fill_const(1, 0);
    run_frame("after_rst", FRAME, 1'b0, 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, FRAME);
      last_flag = (n < FRAME) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < FRAME; i++) begin
        sa[i] = $urandom_range(0, 15);
        sb[i] = $urandom_range(0, 15);
      end
      run_frame($sformatf("rnd%0d", f), n, last_flag, $urandom_range(0, 3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
